// File: rtl/seq_dp_pkg.sv
// Shared encodings for the sequenced register datapath: ALU op codes and
// micro-sequencer states, plus small op-class helpers.
package seq_dp_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_SHL  = 3'd4,
    OP_MUL  = 3'd5,
    OP_ADDI = 3'd6,
    OP_NOP  = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_TY   = 3'd1,
    S_TALU = 3'd2,
    S_TMUL = 3'd3,
    S_TWB  = 3'd4
  } state_e;

  // Ops whose carry-out is architecturally visible.
  function automatic logic is_arith(op_e o);
    return (o == OP_ADD) || (o == OP_SUB) || (o == OP_ADDI);
  endfunction

  // MUL targets HI/LO and NOP writes nothing; everything else lands in R[rd].
  function automatic logic writes_rd(op_e o);
    return (o != OP_MUL) && (o != OP_NOP);
  endfunction

endpackage

// File: rtl/seq_dp_alu.sv
// Combinational single-cycle ALU: ADD/ADDI/SUB with carry-out, AND, OR, SHL.
// Iterative MUL is handled by the sequencer, not here.
module seq_dp_alu
  import seq_dp_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH:0] sum;

  always_comb begin
    sum    = '0;
    result = '0;
    carry  = 1'b0;
    case (op)
      OP_ADD, OP_ADDI: begin
        sum    = {1'b0, a} + {1'b0, b};
        result = sum[WIDTH-1:0];
        carry  = sum[WIDTH];
      end
      // Two's-complement subtract: carry=1 means no borrow.
      OP_SUB: begin
        sum    = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        result = sum[WIDTH-1:0];
        carry  = sum[WIDTH];
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_SHL:  result = a << b[SHW-1:0];
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/seq_datapath.sv
// Bus-based register datapath with a micro-sequencer: one op per start handshake,
// stepping R[rs]->Y, R[rt]/imm->ALU->Z, Z->R[rd]; MUL iterates shift-add into HI/LO.
module seq_datapath
  import seq_dp_pkg::*;
#(
  parameter  int WIDTH    = 32,
  parameter  int NUM_REGS = 16,
  localparam int RAW      = $clog2(NUM_REGS)
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [RAW-1:0]   rs,
  input  logic [RAW-1:0]   rt,
  input  logic [RAW-1:0]   rd,
  input  logic [WIDTH-1:0] imm,
  input  logic             ext_we,
  input  logic [RAW-1:0]   ext_addr,
  input  logic [WIDTH-1:0] ext_wdata,
  input  logic [RAW-1:0]   dbg_addr,
  output logic [WIDTH-1:0] dbg_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             carry,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  state_e           state, state_nxt;
  logic [WIDTH-1:0] regs [NUM_REGS];
  op_e              op_q;
  logic [RAW-1:0]   rs_q, rt_q, rd_q;
  logic [WIDTH-1:0] imm_q;
  logic [WIDTH-1:0] y;
  logic [2*WIDTH-1:0] z;
  logic [WIDTH-1:0] bus;
  logic [WIDTH-1:0] alu_res;
  logic             alu_cy;
  logic             cy_pend;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   mul_sum;
  logic             accept;

  // done keeps busy high for its cycle so a start there is not taken.
  assign busy     = (state != S_IDLE) || done;
  assign dbg_data = regs[dbg_addr];

  always_comb begin
    bus = regs[rs_q];
    if (state != S_TY) bus = (op_q == OP_ADDI) ? imm_q : regs[rt_q];
  end

  // Shift-add step: Z = {acc, multiplier}; add Y into acc when the low bit is set.
  assign mul_sum = {1'b0, z[2*WIDTH-1:WIDTH]} + {1'b0, (z[0] ? y : {WIDTH{1'b0}})};

  seq_dp_alu #(.WIDTH(WIDTH)) u_alu (
    .op     (op_q),
    .a      (y),
    .b      (bus),
    .result (alu_res),
    .carry  (alu_cy)
  );

  always_ff @(posedge clock or posedge clear) begin
    if (clear) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      S_IDLE: if (start && !done) begin
        accept    = 1'b1;
        state_nxt = S_TY;
      end
      S_TY:    state_nxt = S_TALU;
      S_TALU:  state_nxt = (op_q == OP_MUL) ? S_TMUL : S_TWB;
      S_TMUL:  if (cnt == CW'(WIDTH - 1)) state_nxt = S_TWB;
      S_TWB:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      op_q    <= OP_NOP;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
      imm_q   <= '0;
      y       <= '0;
      z       <= '0;
      hi      <= '0;
      lo      <= '0;
      carry   <= 1'b0;
      cy_pend <= 1'b0;
      cnt     <= '0;
      done    <= 1'b0;
    end else begin
      done <= (state == S_TWB);
      if (accept) begin
        op_q  <= op_e'(op);
        rs_q  <= rs;
        rt_q  <= rt;
        rd_q  <= rd;
        imm_q <= imm;
      end
      if (ext_we && !busy) regs[ext_addr] <= ext_wdata;
      case (state)
        S_TY: y <= bus;
        S_TALU: begin
          if (op_q == OP_MUL) begin
            z   <= {{WIDTH{1'b0}}, bus};
            cnt <= '0;
          end else if (op_q != OP_NOP) begin
            z       <= {{WIDTH{1'b0}}, alu_res};
            cy_pend <= alu_cy;
          end
        end
        S_TMUL: begin
          z   <= {mul_sum, z[WIDTH-1:1]};
          cnt <= cnt + CW'(1);
        end
        // Flags and results commit only here, so an abort leaves no partial state.
        S_TWB: begin
          if (op_q == OP_MUL) begin
            hi <= z[2*WIDTH-1:WIDTH];
            lo <= z[WIDTH-1:0];
          end else if (writes_rd(op_q)) begin
            regs[rd_q] <= z[WIDTH-1:0];
            if (is_arith(op_q)) carry <= cy_pend;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_datapath.sv
// Directed bench for seq_datapath: an op-level model (result computed at accept,
// committed after a fixed latency) checked every cycle, plus literal expectations.
module tb_seq_datapath;

  localparam int W = 32;
  localparam int N = 16;

  logic          clock = 1'b0;
  logic          clear;
  logic          start;
  logic [2:0]    op;
  logic [3:0]    rs, rt, rd;
  logic [W-1:0]  imm;
  logic          ext_we;
  logic [3:0]    ext_addr;
  logic [W-1:0]  ext_wdata;
  logic [3:0]    dbg_addr;
  logic [W-1:0]  dbg_data, hi, lo;
  logic          carry, busy, done;

  seq_datapath #(.WIDTH(W), .NUM_REGS(N)) dut (
    .clock(clock), .clear(clear), .start(start), .op(op),
    .rs(rs), .rt(rt), .rd(rd), .imm(imm),
    .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .hi(hi), .lo(lo), .carry(carry), .busy(busy), .done(done)
  );

  always #50 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Op-level model: state is just the architectural registers plus one pending result.
  logic [W-1:0] m_r [N];
  logic [W-1:0] m_hi = '0, m_lo = '0;
  logic         m_cy = 1'b0, m_done = 1'b0, pend = 1'b0;
  int           left = 0;
  logic [2:0]   p_op;
  logic [3:0]   p_rd;
  logic [W-1:0] p_res, p_hi, p_lo;
  logic         p_cy;

  initial for (int i = 0; i < N; i++) m_r[i] = '0;

  always @(posedge clock) begin : model
    logic          idle, nd;
    logic [W-1:0]  a, b;
    logic [63:0]   prod;
    if (clear) begin
      for (int i = 0; i < N; i++) m_r[i] = '0;
      m_hi = '0; m_lo = '0; m_cy = 1'b0; m_done = 1'b0; pend = 1'b0; left = 0;
    end else begin
      idle = !pend && !m_done;
      nd   = 1'b0;
      if (pend) begin
        left--;
        if (left == 0) begin
          pend = 1'b0;
          nd   = 1'b1;
          case (p_op)
            3'd0, 3'd1, 3'd6: begin m_r[p_rd] = p_res; m_cy = p_cy; end
            3'd2, 3'd3, 3'd4: m_r[p_rd] = p_res;
            3'd5: begin m_hi = p_hi; m_lo = p_lo; end
            default: ;
          endcase
        end
      end
      if (idle) begin
        if (ext_we) m_r[ext_addr] = ext_wdata;
        if (start) begin
          a = m_r[rs];
          b = (op == 3'd6) ? imm : m_r[rt];
          p_op = op; p_rd = rd; p_res = '0; p_cy = 1'b0;
          case (op)
            3'd0, 3'd6: begin p_res = a + b; p_cy = ({1'b0, a} + {1'b0, b}) > 33'hFFFF_FFFF; end
            3'd1: begin p_res = a - b; p_cy = (a >= b); end
            3'd2: p_res = a & b;
            3'd3: p_res = a | b;
            3'd4: p_res = a << b[4:0];
            3'd5: begin prod = 64'(a) * 64'(b); p_hi = prod[63:32]; p_lo = prod[31:0]; end
            default: ;
          endcase
          pend = 1'b1;
          left = (op == 3'd5) ? W + 3 : 3;
        end
      end
      m_done = nd;
    end
  end

  // Every cycle: status outputs, then sweep the debug port over all registers.
  initial begin
    dbg_addr = '0;
    forever begin
      @(posedge clock);
      #2;
      chk("busy", 64'(busy), 64'(pend || m_done));
      chk("done", 64'(done), 64'(m_done));
      chk("hi", 64'(hi), 64'(m_hi));
      chk("lo", 64'(lo), 64'(m_lo));
      chk("carry", 64'(carry), 64'(m_cy));
      for (int i = 0; i < N; i++) begin
        dbg_addr = 4'(i);
        #1;
        chk($sformatf("R%0d", i), 64'(dbg_data), 64'(m_r[i]));
      end
    end
  end

  task automatic ext(input logic [3:0] a, input logic [W-1:0] d);
    @(negedge clock);
    while (busy) @(negedge clock);
    ext_we = 1'b1; ext_addr = a; ext_wdata = d;
    @(negedge clock);
    ext_we = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clock);
      #2;
      n++;
    end while (!done && n < 100);
    chk("done_seen", 64'(done), 64'd1);
  endtask

  task automatic run_op(input logic [2:0] o, input logic [3:0] a, b, d,
                        input logic [W-1:0] im, output int n);
    @(negedge clock);
    while (busy) @(negedge clock);
    op = o; rs = a; rt = b; rd = d; imm = im; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done(n);
  endtask

  int   n, n2;
  logic seen;

  initial begin
    clear = 1'b1; start = 1'b0; op = '0; rs = '0; rt = '0; rd = '0; imm = '0;
    ext_we = 1'b0; ext_addr = '0; ext_wdata = '0;
    repeat (2) @(negedge clock);
    clear = 1'b0;

    // Abort a MUL midway with clear.
    ext(4'd1, 32'd3);
    ext(4'd2, 32'd4);
    @(negedge clock);
    op = 3'd5; rs = 4'd1; rt = 4'd2; rd = 4'd3; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (10) @(negedge clock);
    clear = 1'b1;
    #1;
    chk("clr_busy", 64'(busy), 64'd0);
    chk("clr_done", 64'(done), 64'd0);
    chk("clr_hi", 64'(hi), 64'd0);
    chk("clr_lo", 64'(lo), 64'd0);
    @(negedge clock);
    clear = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clock);
      #2;
      if (done) seen = 1'b1;
    end
    chk("no_done_after_clear", 64'(seen), 64'd0);

    // ADD
    ext(4'd1, 32'd7);
    ext(4'd2, 32'd5);
    run_op(3'd0, 4'd1, 4'd2, 4'd3, '0, n);
    chk("add_latency", 64'(n), 64'd3);
    chk("add_r3", 64'(m_r[3]), 64'd12);
    chk("add_carry", 64'(carry), 64'd0);

    // SUB wrap and no-borrow
    ext(4'd1, 32'd0);
    ext(4'd2, 32'd1);
    run_op(3'd1, 4'd1, 4'd2, 4'd4, '0, n);
    chk("sub_wrap_r4", 64'(m_r[4]), 64'hFFFF_FFFF);
    chk("sub_wrap_carry", 64'(carry), 64'd0);
    ext(4'd1, 32'd5);
    ext(4'd2, 32'd3);
    run_op(3'd1, 4'd1, 4'd2, 4'd4, '0, n);
    chk("sub_r4", 64'(m_r[4]), 64'd2);
    chk("sub_carry", 64'(carry), 64'd1);

    // MUL: rd must be untouched
    ext(4'd1, 32'hFFFF_FFFF);
    ext(4'd2, 32'd2);
    ext(4'd8, 32'h1234);
    run_op(3'd5, 4'd1, 4'd2, 4'd8, '0, n);
    chk("mul_latency", 64'(n), 64'd35);
    chk("mul_hi", 64'(hi), 64'd1);
    chk("mul_lo", 64'(lo), 64'hFFFF_FFFE);
    chk("mul_r8_kept", 64'(m_r[8]), 64'h1234);

    // ADDI aliasing rs==rd, then SHL by 31
    ext(4'd5, 32'd10);
    run_op(3'd6, 4'd5, 4'd0, 4'd5, 32'hFFFF_FFFF, n);
    chk("addi_r5", 64'(m_r[5]), 64'd9);
    chk("addi_carry", 64'(carry), 64'd1);
    ext(4'd6, 32'd1);
    ext(4'd7, 32'd31);
    run_op(3'd4, 4'd6, 4'd7, 4'd6, '0, n);
    chk("shl_r6", 64'(m_r[6]), 64'h8000_0000);
    chk("shl_carry_kept", 64'(carry), 64'd1);

    // AND / OR / NOP
    ext(4'd1, 32'hF0F0);
    ext(4'd2, 32'h0FF0);
    run_op(3'd2, 4'd1, 4'd2, 4'd11, '0, n);
    chk("and_r11", 64'(m_r[11]), 64'h00F0);
    run_op(3'd3, 4'd1, 4'd2, 4'd12, '0, n);
    chk("or_r12", 64'(m_r[12]), 64'hFFF0);
    run_op(3'd7, 4'd1, 4'd2, 4'd1, '0, n);
    chk("nop_latency", 64'(n), 64'd3);
    chk("nop_r1_kept", 64'(m_r[1]), 64'hF0F0);

    // ext write and start in the same idle cycle: op sees the new value
    @(negedge clock);
    while (busy) @(negedge clock);
    ext_we = 1'b1; ext_addr = 4'd1; ext_wdata = 32'h64;
    op = 3'd0; rs = 4'd1; rt = 4'd2; rd = 4'd13; start = 1'b1;
    @(negedge clock);
    ext_we = 1'b0; start = 1'b0;
    wait_done(n);
    chk("ext_start_r13", 64'(m_r[13]), 64'h1054);

    // Contention: start/ext_we while busy are dropped; start held over done is taken next cycle
    @(negedge clock);
    while (busy) @(negedge clock);
    op = 3'd0; rs = 4'd1; rt = 4'd2; rd = 4'd3; start = 1'b1;
    @(negedge clock);
    op = 3'd1; rd = 4'd10;
    ext_we = 1'b1; ext_addr = 4'd9; ext_wdata = 32'hAA;
    wait_done(n);
    chk("cont_first_latency", 64'(n), 64'd3);
    @(negedge clock);
    ext_we = 1'b0;
    @(negedge clock);
    @(negedge clock);
    start = 1'b0;
    wait_done(n2);
    chk("cont_second_latency", 64'(n2), 64'd3);
    chk("cont_r3", 64'(m_r[3]), 64'h1054);
    chk("cont_r10", 64'(m_r[10]), 64'hFFFF_F074);
    chk("cont_r9_ignored", 64'(m_r[9]), 64'd0);

    repeat (3) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
